sym_err_aligner: RTL
====================

# sym_err_aligner

Receive-side symbol error checker for the 4-ASK in-phase path. It takes the transmitted 2-bit symbol stream (`tx_data[1:0]`) and the sliced receive symbols, and finds the end-to-end symbol delay by searching for it. It then counts symbol errors over fixed windows. This replaces the hand-set delay constant in the data-delay path; the team uses it in benches and on hardware whenever the filter chain changes.

## Interface
Parameters:
- `MAX_DELAY`, default 63: largest candidate delay in symbols; the history depth is `MAX_DELAY+1`.
- `DELAY_W`, default 6: width of the delay registers; must hold `MAX_DELAY`.
- `TRIAL_LEN`, default 64: number of symbols compared per candidate delay.
- `LOCK_ERR_MAX`, default 2: maximum errors in a trial that still counts as a lock.
- `WIN_LOG2`, default 10: the measurement window is 2^WIN_LOG2 symbols.
- `LOSS_ERR_MAX`, default 64: if a window has more errors than this, lock is declared lost.

Ports (clock and reset first):
- `clk`, in, 1: system clock (`sys_clk`).
- `reset`, in, 1: asynchronous, active-low reset.
- `sym_clk_en`, in, 1: symbol-rate enable. All state advances only when this is high.
- `start`, in, 1: synchronous restart of the search. Sampled on `sym_clk_en` cycles.
- `tx_sym`, in, 2: transmitted symbol.
- `rx_sym`, in, 2: sliced receive symbol.
- `locked`, out, 1: high while in LOCKED.
- `fail`, out, 1: high while in FAIL.
- `delay_out`, out, DELAY_W: current candidate delay, or the locked delay.
- `err_count`, out, WIN_LOG2+1: symbol errors in the last completed window.
- `window_done`, out, 1: one-`clk` pulse when `err_count` updates.

## Operation
- The history line shifts `tx_sym` in on every `sym_clk_en`. The tap at candidate `d` gives `tx_sym` delayed by `d` symbols. A compare is a mismatch between `rx_sym` and that tap.
- States: FILL, SEARCH, LOCKED, FAIL.
- **FILL**: count `MAX_DELAY+1` symbols, then go to SEARCH with `d=0`.
- **SEARCH**:
  - Compare for TRIAL_LEN symbols. The error total includes the current symbol's compare.
  - On the last trial symbol, if errors ≤ LOCK_ERR_MAX, go to LOCKED and keep `d`.
  - Otherwise, if `d` < MAX_DELAY, increment `d` and clear the trial counters.
  - Otherwise go to FAIL.
- **LOCKED**:
  - Accumulate errors over the window.
  - On the last window symbol, register the window total into `err_count` and pulse `window_done`.
  - If the total exceeds LOSS_ERR_MAX, go to SEARCH with `d=0`. `err_count` still updates.
- **FAIL**: hold all outputs. Leave only on `start` or reset.
- `start` in any state goes to SEARCH with `d=0` and clears the trial and window counters. The history is kept, so FILL is skipped.
- Simultaneous events: `start` beats trial completion and window completion. In that case there is no `window_done` and `err_count` is unchanged.
- Counters saturate and never wrap. The error counter has WIN_LOG2+1 bits, so an all-error window reads 2^WIN_LOG2.

## Timing
- Reset values: state FILL, `locked=0`, `fail=0`, `delay_out=0`, `err_count=0`, `window_done=0`, history all zeros.
- Reset mid-operation clears everything immediately, asynchronously.
- All outputs are registered.
- A state or delay change decided on `sym_clk_en` cycle k is visible at k+1 `clk`. The next symbol's compare uses the new `d`.
- `window_done` is high for exactly one `clk`, the cycle after the final window symbol's enable.
- Lock time for true delay D is `(MAX_DELAY+1) + (D+1)·TRIAL_LEN` symbols after reset.

## Configuration
- Macro: `SYM_ERR_BIT_EN`.
- When defined:
  - Adds output `bit_err_count` [WIN_LOG2+1:0]: the bit-error total per window, where each symbol contributes popcount(`rx_sym` ^ tap), i.e. 0–2.
  - It registers and resets exactly like `err_count` and updates on the same `window_done`.
- When undefined: the port and its logic are absent. Symbol behaviour is identical in both builds.

## Structure
- Shared package or defines header:
  - State encodings (`SEA_FILL`, `SEA_SEARCH`, `SEA_LOCKED`, `SEA_FAIL`).
  - Default parameter constants.
- One sub-module, `sym_hist_delay`:
  - A 2-bit-wide tapped shift register of depth `MAX_DELAY+1`, enabled by `sym_clk_en`.
  - Has a combinational read at index `d`.
- The top level holds the FSM, trial/window counters and output registers.

## Test plan
- **Nominal lock.** Drive the LFSR `tx_sym` and set `rx_sym` = `tx_sym` delayed 38 symbols, with no errors. Required: `locked=1` and `delay_out=38` after 64+39·64 = 2560 symbols, and every window gives `err_count=0`.
- **Isolated errors.** After lock, invert one `rx_sym` per 1024 symbols (WIN_LOG2=10). Required: `window_done` every 1024 symbols with `err_count=1`, and `locked` stays 1.
- **Delay out of range.** Set the true delay to 70 (> MAX_DELAY). Required: `fail=1`, `locked=0`, `delay_out=63` after 64+64·64 symbols. Then pulse `start`: SEARCH restarts with `delay_out=0`.
- **Loss and relock.** After lock, replace `rx_sym` with random data for one window. Required: `err_count>64`, `locked` drops the cycle after `window_done`, and the block relocks at 38 once clean data returns.
- **Reset mid-search.** Drive `reset=0` while `delay_out=12`. Required: all outputs are 0 immediately, and after release `locked` stays 0 for at least 64 symbols (FILL).
- **Bit count (`SYM_ERR_BIT_EN` defined).** After lock, inject one error as `tx`=2'b00 → `rx`=2'b11. Required: `err_count=1` and `bit_err_count=2`.

Source files
------------

// File: rtl/sym_err_aligner_pkg.sv
// Shared state encodings and default parameters for the 4-ASK symbol delay aligner.
package sym_err_aligner_pkg;

  typedef enum logic [1:0] {
    SEA_FILL   = 2'd0,
    SEA_SEARCH = 2'd1,
    SEA_LOCKED = 2'd2,
    SEA_FAIL   = 2'd3
  } sea_state_t;

  localparam int SEA_MAX_DELAY    = 63;
  localparam int SEA_DELAY_W      = 6;
  localparam int SEA_TRIAL_LEN    = 64;
  localparam int SEA_LOCK_ERR_MAX = 2;
  localparam int SEA_WIN_LOG2     = 10;
  localparam int SEA_LOSS_ERR_MAX = 64;

  function automatic int sea_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sym_err_aligner_hist.sv
// sym_hist_delay: tapped 2-bit history of the transmitted symbols; tap d is tx_sym delayed by d symbols.
module sym_hist_delay
  import sym_err_aligner_pkg::*;
#(
  parameter int MAX_DELAY = SEA_MAX_DELAY,
  parameter int DELAY_W   = SEA_DELAY_W
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic [1:0]         din,
  input  logic [DELAY_W-1:0] sel,
  output logic [1:0]         tap
);

  // Delay 0 is the live input, so only MAX_DELAY registered stages are needed.
  logic [1:0] hist [1:MAX_DELAY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= MAX_DELAY; i++) hist[i] <= 2'b00;
    end else if (sym_clk_en) begin
      hist[1] <= din;
      for (int i = 2; i <= MAX_DELAY; i++) hist[i] <= hist[i-1];
    end
  end

  always_comb begin
    tap = din;
    for (int i = 1; i <= MAX_DELAY; i++) begin
      if (sel == DELAY_W'(i)) tap = hist[i];
    end
  end

endmodule

// File: rtl/sym_err_aligner.sv
// sym_err_aligner: searches for the tx->rx symbol delay, then counts symbol errors per window.
// Defining SYM_ERR_BIT_EN adds the bit_err_count output (per-window bit-error total).
module sym_err_aligner
  import sym_err_aligner_pkg::*;
#(
  parameter int MAX_DELAY    = SEA_MAX_DELAY,
  parameter int DELAY_W      = SEA_DELAY_W,
  parameter int TRIAL_LEN    = SEA_TRIAL_LEN,
  parameter int LOCK_ERR_MAX = SEA_LOCK_ERR_MAX,
  parameter int WIN_LOG2     = SEA_WIN_LOG2,
  parameter int LOSS_ERR_MAX = SEA_LOSS_ERR_MAX
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic               start,
  input  logic [1:0]         tx_sym,
  input  logic [1:0]         rx_sym,
  output logic               locked,
  output logic               fail,
  output logic [DELAY_W-1:0] delay_out,
  output logic [WIN_LOG2:0]  err_count,
  output logic               window_done
`ifdef SYM_ERR_BIT_EN
  ,
  output logic [WIN_LOG2+1:0] bit_err_count
`endif
);

  // state  | meaning
  // FILL   | history filling after reset, no compares
  // SEARCH | trialling candidate delay delay_out
  // LOCKED | delay fixed, counting errors per window
  // FAIL   | no candidate locked, outputs held until start

  localparam int TE_W  = $clog2(TRIAL_LEN + 1);
  localparam int WE_W  = WIN_LOG2 + 1;
  localparam int TMR_W = sea_max(DELAY_W, sea_max($clog2(TRIAL_LEN), WIN_LOG2));

  localparam logic [TMR_W-1:0] FILL_LD  = TMR_W'(MAX_DELAY);
  localparam logic [TMR_W-1:0] TRIAL_LD = TMR_W'(TRIAL_LEN - 1);
  localparam logic [TMR_W-1:0] WIN_LD   = TMR_W'((1 << WIN_LOG2) - 1);
  localparam logic [TE_W-1:0]  TE_MAX   = {TE_W{1'b1}};
  localparam logic [WE_W-1:0]  WE_MAX   = {WE_W{1'b1}};

  sea_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic [TE_W-1:0]  trial_err, trial_tot;
  logic [WE_W-1:0]  win_err, win_tot;
  logic [1:0]       tap;
  logic             mis;

  sym_hist_delay #(
    .MAX_DELAY (MAX_DELAY),
    .DELAY_W   (DELAY_W)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .sym_clk_en (sym_clk_en),
    .din        (tx_sym),
    .sel        (delay_out),
    .tap        (tap)
  );

  // Totals include the current symbol's compare and saturate instead of wrapping.
  always_comb begin
    mis       = (rx_sym != tap);
    trial_tot = (trial_err == TE_MAX) ? trial_err : trial_err + TE_W'(mis);
    win_tot   = (win_err == WE_MAX) ? win_err : win_err + WE_W'(mis);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEA_FILL;
      tmr         <= FILL_LD;
      delay_out   <= '0;
      trial_err   <= '0;
      win_err     <= '0;
      err_count   <= '0;
      window_done <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (sym_clk_en) begin
        if (start) begin
          state     <= SEA_SEARCH;
          tmr       <= TRIAL_LD;
          delay_out <= '0;
          trial_err <= '0;
          win_err   <= '0;
          locked    <= 1'b0;
          fail      <= 1'b0;
        end else begin
          case (state)
            SEA_FILL: begin
              if (tmr == '0) begin
                state     <= SEA_SEARCH;
                tmr       <= TRIAL_LD;
                delay_out <= '0;
                trial_err <= '0;
              end else begin
                tmr <= tmr - 1'b1;
              end
            end
            SEA_SEARCH: begin
              if (tmr == '0) begin
                trial_err <= '0;
                if (32'(trial_tot) <= LOCK_ERR_MAX) begin
                  state   <= SEA_LOCKED;
                  locked  <= 1'b1;
                  tmr     <= WIN_LD;
                  win_err <= '0;
                end else if (delay_out < DELAY_W'(MAX_DELAY)) begin
                  delay_out <= delay_out + 1'b1;
                  tmr       <= TRIAL_LD;
                end else begin
                  state <= SEA_FAIL;
                  fail  <= 1'b1;
                end
              end else begin
                tmr       <= tmr - 1'b1;
                trial_err <= trial_tot;
              end
            end
            SEA_LOCKED: begin
              if (tmr == '0) begin
                err_count   <= win_tot;
                window_done <= 1'b1;
                win_err     <= '0;
                tmr         <= WIN_LD;
                if (32'(win_tot) > LOSS_ERR_MAX) begin
                  state     <= SEA_SEARCH;
                  locked    <= 1'b0;
                  delay_out <= '0;
                  tmr       <= TRIAL_LD;
                  trial_err <= '0;
                end
              end else begin
                tmr     <= tmr - 1'b1;
                win_err <= win_tot;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef SYM_ERR_BIT_EN
  localparam int BE_W = WIN_LOG2 + 2;

  logic [BE_W-1:0] bit_err, bit_tot;
  logic [1:0]      bit_x, bit_mis;

  // A full window of 2-bit errors is 2^(WIN_LOG2+1), which fits BE_W, so no saturation is needed.
  always_comb begin
    bit_x   = rx_sym ^ tap;
    bit_mis = {bit_x[1] & bit_x[0], bit_x[1] ^ bit_x[0]};
    bit_tot = bit_err + BE_W'(bit_mis);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_err       <= '0;
      bit_err_count <= '0;
    end else if (sym_clk_en) begin
      if (start) begin
        bit_err <= '0;
      end else if (state == SEA_LOCKED) begin
        if (tmr == '0) begin
          bit_err_count <= bit_tot;
          bit_err       <= '0;
        end else begin
          bit_err <= bit_tot;
        end
      end
    end
  end
`endif

endmodule
